// File: rtl/branch_cond_unit.sv
// ----------------------------------------------------------------------------
// branch_cond_unit
//
// Resolves conditional branches against the z/v/n flags of the 16-bit ALU.
// Flags from flag-setting ALU ops are held in a small flag register with a
// valid bit. Branch requests arrive over a valid/ready handshake. A request
// whose condition needs flags waits until the flag register is valid. The
// resolved next PC is then offered over a second valid/ready handshake.
//
// Ports
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-high reset
//   flag_inv   flag-setting ALU op issued; flags become not-valid
//   flag_we    flag-setting ALU op completes; capture z/v/n
//   z, v, n    ALU zero / signed-overflow / negative flags
//   br_req     branch request valid
//   br_ready   unit can accept a request (high only in IDLE)
//   br_cond    condition code (EQ NE LT GE LE GT ALWAYS NEVER)
//   br_target  PC if taken
//   br_fall    PC if not taken
//   flush      abandon any branch in progress
//   res_valid  resolution available
//   res_ready  consumer accepts resolution
//   res_taken  branch taken
//   res_pc     next PC
//   taken_cnt  saturating count of taken resolutions
// ----------------------------------------------------------------------------
module branch_cond_unit #(
    parameter int PC_W = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flag_inv,
    input  logic            flag_we,
    input  logic            z,
    input  logic            v,
    input  logic            n,
    input  logic            br_req,
    output logic            br_ready,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] br_fall,
    input  logic            flush,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_taken,
    output logic [PC_W-1:0] res_pc,
    output logic [15:0]     taken_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // flag register
    logic fz_q, fv_q, fn_q, fvalid_q;

    // latched branch request
    logic [2:0]      cond_q;
    logic [PC_W-1:0] target_q;
    logic [PC_W-1:0] fall_q;

    // registered results
    logic            res_valid_q;
    logic            res_taken_q;
    logic [PC_W-1:0] res_pc_q;
    logic [15:0]     taken_cnt_q;

    // datapath control
    logic            accept;
    logic            uncond;
    logic            resolve_now;
    logic            load_taken;
    logic [PC_W-1:0] load_pc;

    function automatic logic cond_eval(input logic [2:0] c,
                                       input logic fz, input logic fv,
                                       input logic fn);
        logic lt;
        logic r;
        lt = fn ^ fv;
        r  = 1'b0;
        case (c)
            3'b000:  r = fz;
            3'b001:  r = ~fz;
            3'b010:  r = lt;
            3'b011:  r = ~lt;
            3'b100:  r = fz | lt;
            3'b101:  r = ~fz & ~lt;
            3'b110:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic. flush overrides everything, including a
    // request presented in IDLE the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (br_req) begin
                        // ALWAYS/NEVER need no flags and resolve at accept
                        state_d = (br_cond[2:1] == 2'b11) ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    // only the registered valid bit counts; a flag_inv this
                    // cycle does not block, and flag_we is not bypassed
                    if (fvalid_q) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // FSM: output decode
    // ------------------------------------------------------------------
    always_comb begin
        br_ready = (state_q == S_IDLE);
    end

    // ------------------------------------------------------------------
    // Result selection: a result is loaded exactly when DONE is entered
    // ------------------------------------------------------------------
    always_comb begin
        accept      = (state_q == S_IDLE) && br_req && !flush;
        uncond      = (br_cond[2:1] == 2'b11);
        resolve_now = 1'b0;
        load_taken  = 1'b0;
        load_pc     = '0;
        if (accept && uncond) begin
            resolve_now = 1'b1;
            load_taken  = ~br_cond[0];
            load_pc     = load_taken ? br_target : br_fall;
        end else if ((state_q == S_WAIT) && fvalid_q && !flush) begin
            resolve_now = 1'b1;
            load_taken  = cond_eval(cond_q, fz_q, fv_q, fn_q);
            load_pc     = load_taken ? target_q : fall_q;
        end
    end

    // ------------------------------------------------------------------
    // Flag register. With flag_inv and flag_we together the data is
    // captured but stays invalid: a newer producer owns the flags.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fz_q     <= 1'b0;
            fv_q     <= 1'b0;
            fn_q     <= 1'b0;
            fvalid_q <= 1'b0;
        end else begin
            if (flag_we) begin
                fz_q <= z;
                fv_q <= v;
                fn_q <= n;
            end
            if (flag_inv) begin
                fvalid_q <= 1'b0;
            end else if (flag_we) begin
                fvalid_q <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Request latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cond_q   <= 3'b000;
            target_q <= '0;
            fall_q   <= '0;
        end else if (accept) begin
            cond_q   <= br_cond;
            target_q <= br_target;
            fall_q   <= br_fall;
        end
    end

    // ------------------------------------------------------------------
    // Result registers and taken counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid_q <= 1'b0;
            res_taken_q <= 1'b0;
            res_pc_q    <= '0;
            taken_cnt_q <= 16'h0000;
        end else begin
            res_valid_q <= (state_d == S_DONE);
            // result held stable while in DONE: only loaded on DONE entry
            if (resolve_now) begin
                res_taken_q <= load_taken;
                res_pc_q    <= load_pc;
                if (load_taken && (taken_cnt_q != 16'hFFFF)) begin
                    taken_cnt_q <= taken_cnt_q + 16'h0001;
                end
            end
        end
    end

    assign res_valid = res_valid_q;
    assign res_taken = res_taken_q;
    assign res_pc    = res_pc_q;
    assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_branch_cond_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_cond_unit
//
// Directed bench for branch_cond_unit: a table of flag/condition vectors
// with hand-computed outcomes, then hand-written sequences for stalls,
// backpressure, flush, counter saturation and asynchronous reset.
// ----------------------------------------------------------------------------
module tb_branch_cond_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flag_inv, flag_we, z, v, n;
    logic        br_req, br_ready;
    logic [2:0]  br_cond;
    logic [15:0] br_target, br_fall;
    logic        flush;
    logic        res_valid, res_ready, res_taken;
    logic [15:0] res_pc;
    logic [15:0] taken_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    branch_cond_unit #(.PC_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .flag_inv  (flag_inv),
        .flag_we   (flag_we),
        .z         (z),
        .v         (v),
        .n         (n),
        .br_req    (br_req),
        .br_ready  (br_ready),
        .br_cond   (br_cond),
        .br_target (br_target),
        .br_fall   (br_fall),
        .flush     (flush),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_taken (res_taken),
        .res_pc    (res_pc),
        .taken_cnt (taken_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        z, v, n;
        logic [2:0]  cond;
        logic [15:0] target;
        logic [15:0] fall;
        logic        exp_taken;
        int          exp_lat;
    } vec_t;

    vec_t vecs[15];

    // drive and sample 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_flags(input logic fz, input logic fv, input logic fn);
        flag_we = 1'b1; z = fz; v = fv; n = fn;
        tick();
        flag_we = 1'b0;
    endtask

    task automatic issue(input logic [2:0] c, input logic [15:0] t,
                         input logic [15:0] f);
        br_req = 1'b1; br_cond = c; br_target = t; br_fall = f;
        tick();
        br_req = 1'b0;
    endtask

    // latency counted in edges from the accept edge
    task automatic wait_res(input string name, output int lat);
        lat = 1;
        while (!res_valid && lat < 20) begin
            tick();
            lat++;
        end
        if (!res_valid) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic handshake(input string name);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check({name, "_hs_valid"}, 32'(res_valid), 32'd0);
        check({name, "_hs_ready"}, 32'(br_ready), 32'd1);
    endtask

    initial begin
        int          lat;
        logic [15:0] exp_cnt;
        logic [15:0] hold_pc;
        logic        hold_taken;

        //             z  v  n  cond    target    fall      tk lat
        vecs[0]  = '{1'b1,1'b0,1'b0,3'b000,16'h0040,16'h0012,1'b1,2}; // EQ
        vecs[1]  = '{1'b0,1'b0,1'b0,3'b000,16'h0100,16'h0102,1'b0,2}; // EQ
        vecs[2]  = '{1'b0,1'b0,1'b0,3'b001,16'h0200,16'h0202,1'b1,2}; // NE
        vecs[3]  = '{1'b1,1'b0,1'b0,3'b001,16'h0300,16'h0302,1'b0,2}; // NE
        vecs[4]  = '{1'b0,1'b0,1'b1,3'b010,16'h0400,16'h0402,1'b1,2}; // LT
        vecs[5]  = '{1'b0,1'b1,1'b1,3'b010,16'h0500,16'h0502,1'b0,2}; // LT
        vecs[6]  = '{1'b0,1'b1,1'b0,3'b011,16'h0600,16'h0602,1'b0,2}; // GE
        vecs[7]  = '{1'b0,1'b0,1'b0,3'b011,16'h0700,16'h0702,1'b1,2}; // GE
        vecs[8]  = '{1'b1,1'b0,1'b0,3'b100,16'h0800,16'h0802,1'b1,2}; // LE
        vecs[9]  = '{1'b0,1'b0,1'b0,3'b100,16'h0900,16'h0902,1'b0,2}; // LE
        vecs[10] = '{1'b0,1'b1,1'b1,3'b101,16'h0A00,16'h0A02,1'b1,2}; // GT
        vecs[11] = '{1'b0,1'b0,1'b1,3'b101,16'h0B00,16'h0B02,1'b0,2}; // GT
        vecs[12] = '{1'b1,1'b0,1'b0,3'b101,16'h0C00,16'h0C02,1'b0,2}; // GT
        vecs[13] = '{1'b0,1'b0,1'b0,3'b110,16'h0D00,16'h0D02,1'b1,1}; // ALW
        vecs[14] = '{1'b1,1'b1,1'b1,3'b111,16'h0E00,16'h0E02,1'b0,1}; // NEV

        rst = 1'b1; flag_inv = 0; flag_we = 0; z = 0; v = 0; n = 0;
        br_req = 0; br_cond = 0; br_target = 0; br_fall = 0;
        flush = 0; res_ready = 0;
        tick(); tick();
        rst = 1'b0;
        tick();

        // reset state
        check("rst_br_ready",  32'(br_ready),  32'd1);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_taken", 32'(res_taken), 32'd0);
        check("rst_res_pc",    32'(res_pc),    32'd0);
        check("rst_taken_cnt", 32'(taken_cnt), 32'd0);
        exp_cnt = 16'h0000;

        // table of condition codes with valid flags
        for (int i = 0; i < 15; i++) begin
            set_flags(vecs[i].z, vecs[i].v, vecs[i].n);
            issue(vecs[i].cond, vecs[i].target, vecs[i].fall);
            wait_res($sformatf("vec%0d", i), lat);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d_taken", i), 32'(res_taken),
                  32'(vecs[i].exp_taken));
            check($sformatf("vec%0d_pc", i), 32'(res_pc),
                  32'(vecs[i].exp_taken ? vecs[i].target : vecs[i].fall));
            if (vecs[i].exp_taken) exp_cnt = exp_cnt + 16'd1;
            check($sformatf("vec%0d_cnt", i), 32'(taken_cnt), 32'(exp_cnt));
            handshake($sformatf("vec%0d", i));
            $display("vec %0d cond=%b taken=%0d pc=%h lat=%0d cnt=%0d",
                     i, vecs[i].cond, res_taken, res_pc, lat, taken_cnt);
        end

        // stall on pending flags (LT, lt = 0 once flags arrive)
        flag_inv = 1'b1; tick(); flag_inv = 1'b0;
        issue(3'b010, 16'h1000, 16'h1002);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall_valid%0d", k), 32'(res_valid), 32'd0);
            check($sformatf("stall_ready%0d", k), 32'(br_ready), 32'd0);
            tick();
        end
        set_flags(1'b0, 1'b1, 1'b1);
        check("stall_no_bypass", 32'(res_valid), 32'd0);
        tick();
        check("stall_valid", 32'(res_valid), 32'd1);
        check("stall_taken", 32'(res_taken), 32'd0);
        check("stall_pc",    32'(res_pc),    32'h1002);
        handshake("stall");
        $display("stall LT resolved taken=0 pc=1002");

        // backpressure: GT taken held while flags change underneath
        set_flags(1'b0, 1'b0, 1'b0);
        issue(3'b101, 16'h2000, 16'h2002);
        wait_res("bp", lat);
        exp_cnt = exp_cnt + 16'd1;
        hold_pc = res_pc; hold_taken = res_taken;
        check("bp_taken", 32'(res_taken), 32'd1);
        check("bp_pc",    32'(res_pc),    32'h2000);
        for (int k = 0; k < 4; k++) begin
            flag_we = 1'b1; z = 1'(k); v = 1'b1; n = 1'b0;
            tick();
            flag_we = 1'b0;
            check($sformatf("bp_hold_valid%0d", k), 32'(res_valid), 32'd1);
            check($sformatf("bp_hold_pc%0d", k),    32'(res_pc),    32'(hold_pc));
            check($sformatf("bp_hold_tk%0d", k),    32'(res_taken), 32'(hold_taken));
            check($sformatf("bp_hold_rdy%0d", k),   32'(br_ready),  32'd0);
        end
        check("bp_cnt", 32'(taken_cnt), 32'(exp_cnt));
        handshake("bp");
        $display("backpressure GT held pc=%h cnt=%0d", hold_pc, taken_cnt);

        // flag_inv + flag_we together: data captured but invalid
        flag_inv = 1'b1; flag_we = 1'b1; z = 1'b1; v = 1'b0; n = 1'b0;
        tick();
        flag_inv = 1'b0; flag_we = 1'b0;
        issue(3'b001, 16'h3000, 16'h3002);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("both_wait%0d", k), 32'(res_valid), 32'd0);
            tick();
        end
        set_flags(1'b0, 1'b0, 1'b0);
        tick();
        check("both_valid", 32'(res_valid), 32'd1);
        check("both_taken", 32'(res_taken), 32'd1);
        check("both_pc",    32'(res_pc),    32'h3000);
        exp_cnt = exp_cnt + 16'd1;
        check("both_cnt",   32'(taken_cnt), 32'(exp_cnt));
        handshake("both");
        $display("inv+we then NE taken pc=3000");

        // flush in WAIT
        flag_inv = 1'b1; tick(); flag_inv = 1'b0;
        issue(3'b000, 16'h4000, 16'h4002);
        tick();
        flush = 1'b1; tick(); flush = 1'b0;
        check("flw_valid", 32'(res_valid), 32'd0);
        check("flw_ready", 32'(br_ready),  32'd1);
        set_flags(1'b1, 1'b0, 1'b0);
        tick();
        check("flw_dropped", 32'(res_valid), 32'd0);
        check("flw_cnt",     32'(taken_cnt), 32'(exp_cnt));
        $display("flush in WAIT discarded");

        // flush in DONE: the entry was already counted
        issue(3'b110, 16'h5000, 16'h5002);
        exp_cnt = exp_cnt + 16'd1;
        check("fld_valid_pre", 32'(res_valid), 32'd1);
        flush = 1'b1; tick(); flush = 1'b0;
        check("fld_valid", 32'(res_valid), 32'd0);
        check("fld_ready", 32'(br_ready),  32'd1);
        check("fld_cnt",   32'(taken_cnt), 32'(exp_cnt));
        $display("flush in DONE dropped result cnt=%0d", taken_cnt);

        // flush with br_req in IDLE: nothing accepted
        flush = 1'b1;
        issue(3'b110, 16'h6000, 16'h6002);
        flush = 1'b0;
        tick();
        check("flr_valid", 32'(res_valid), 32'd0);
        check("flr_ready", 32'(br_ready),  32'd1);
        check("flr_cnt",   32'(taken_cnt), 32'(exp_cnt));
        $display("flush+req in IDLE ignored");

        // counter saturation from a preloaded value
        dut.taken_cnt_q = 16'hFFFE;
        issue(3'b110, 16'h7000, 16'h7002);
        check("sat_cnt1", 32'(taken_cnt), 32'hFFFF);
        handshake("sat1");
        issue(3'b110, 16'h7100, 16'h7102);
        check("sat_pc",   32'(res_pc),    32'h7100);
        check("sat_cnt2", 32'(taken_cnt), 32'hFFFF);
        handshake("sat2");
        $display("saturation cnt=%h", taken_cnt);

        // asynchronous reset mid-branch
        set_flags(1'b1, 1'b0, 1'b0);
        issue(3'b001, 16'h8000, 16'h8002);
        #2 rst = 1'b1;
        #1;
        check("arst_ready", 32'(br_ready),  32'd1);
        check("arst_valid", 32'(res_valid), 32'd0);
        check("arst_taken", 32'(res_taken), 32'd0);
        check("arst_pc",    32'(res_pc),    32'd0);
        check("arst_cnt",   32'(taken_cnt), 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("arst_idle", 32'(res_valid), 32'd0);
        // flags were cleared by reset, so a conditional must wait
        issue(3'b000, 16'h9000, 16'h9002);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("arst_fwait%0d", k), 32'(res_valid), 32'd0);
            tick();
        end
        flush = 1'b1; tick(); flush = 1'b0;
        check("arst_flush_ready", 32'(br_ready), 32'd1);
        $display("async reset cleared state cnt=%0d", taken_cnt);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // hard time limit so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
